// File: rtl/dec_nx2n_bist_pkg.sv
// Shared definitions for the N-to-2^N decoder with BIST.
//   state_t : sweep controller states
//   SA0/SA1 : fault-type encodings for flt_type
//   onehot  : reference one-hot decode used to build the checker's expected value
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SA0 = 1'b0;
  localparam logic SA1 = 1'b1;

  // Returns 1<<code, clipped to 2**n bits. Callers truncate to their width.
  function automatic logic [63:0] onehot(input logic [5:0] code, input int n);
    logic [63:0] mask;
    mask   = (64'(1) << (1 << n)) - 64'(1);
    onehot = (64'(1) << code) & mask;
  endfunction

endpackage

// File: rtl/dec_nx2n_bist_if.sv
// Bundle of the decoder's functional, fault-injection and BIST signals.
//   master : drives requests, fault controls and bist_start (testbench / system)
//   slave  : the decoder itself
interface dec_nx2n_bist_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic                in_valid;
  logic [N-1:0]        in_code;
  logic                en;
  logic                out_valid;
  logic [(2**N)-1:0]   D;
  logic                flt_en;
  logic [N-1:0]        flt_sel;
  logic                flt_type;
  logic                bist_start;
  logic                bist_busy;
  logic                bist_done;
  logic                bist_pass;
  logic [CNT_W-1:0]    bist_errs;

  modport master (
    output in_valid, in_code, en, flt_en, flt_sel, flt_type, bist_start,
    input  out_valid, D, bist_busy, bist_done, bist_pass, bist_errs
  );

  modport slave (
    input  in_valid, in_code, en, flt_en, flt_sel, flt_type, bist_start,
    output out_valid, D, bist_busy, bist_done, bist_pass, bist_errs
  );
endinterface

// File: rtl/dec_nx2n_bist_core.sv
// Combinational N -> 2^N one-hot decode followed by the fault mask.
//   code_i     : select code
//   en_i       : 0 forces an all-zero decode
//   flt_en_i   : force bit flt_sel_i of the result to flt_type_i
//   flt_sel_i  : faulted bit index
//   flt_type_i : SA0 / SA1
//   d_o        : masked one-hot result
module dec_onehot_core
  import dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]      code_i,
  input  logic              en_i,
  input  logic              flt_en_i,
  input  logic [N-1:0]      flt_sel_i,
  input  logic              flt_type_i,
  output logic [(2**N)-1:0] d_o
);

  always_comb begin
    d_o = '0;
    if (en_i) d_o[code_i] = 1'b1;
    // The fault is applied after decode so it also overrides en_i = 0.
    if (flt_en_i) d_o[flt_sel_i] = (flt_type_i == SA1);
  end

endmodule

// File: rtl/dec_nx2n_bist.sv
// Registered N-to-2^N one-hot decoder with fault injection and self-test.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : dec_nx2n_bist_if.slave (request, result, fault and BIST signals)
// A sweep presents codes 0..2^N-1 through the same decode core as functional
// traffic; the expected one-hot value travels one register behind alongside D
// and every registered sweep result is compared against it.
module dec_nx2n_bist
  import dec_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  dec_nx2n_bist_if.slave      bus
);

  localparam int              W       = 2**N;
  localparam logic [N-1:0]    CODE_MAX = {N{1'b1}};
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_t             state_q;
  logic [N-1:0]       cnt_q;
  logic [W-1:0]       d_q;
  logic [W-1:0]       exp_q;
  logic               out_valid_q;
  logic               chk_vld_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [CNT_W-1:0]   errs_q;

  logic [N-1:0]       core_code;
  logic               core_en;
  logic [W-1:0]       core_d;
  logic [W-1:0]       exp_d;
  logic               mism;
  logic [CNT_W-1:0]   errs_d;

  // During a sweep the counter drives the core with the enable forced on.
  assign core_code = (state_q == RUN) ? cnt_q : bus.in_code;
  assign core_en   = (state_q == RUN) ? 1'b1  : bus.en;

  dec_onehot_core #(.N(N)) u_core (
    .code_i     (core_code),
    .en_i       (core_en),
    .flt_en_i   (bus.flt_en),
    .flt_sel_i  (bus.flt_sel),
    .flt_type_i (bus.flt_type),
    .d_o        (core_d)
  );

  assign exp_d = W'(onehot(6'(cnt_q), N));

  // chk_vld_q marks a register pair loaded by the sweep; outside a sweep it is
  // low so errs_d simply holds.
  assign mism   = chk_vld_q && (d_q != exp_q);
  assign errs_d = (mism && (errs_q != ERR_MAX)) ? errs_q + 1'b1 : errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      chk_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errs_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      chk_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      errs_q      <= errs_d;
      case (state_q)
        IDLE: begin
          // bist_start has priority; a simultaneous request is dropped.
          if (bus.bist_start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            errs_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (bus.in_valid) begin
            d_q         <= core_d;
            out_valid_q <= 1'b1;
          end
        end
        RUN: begin
          d_q         <= core_d;
          exp_q       <= exp_d;
          out_valid_q <= 1'b1;
          chk_vld_q   <= 1'b1;
          cnt_q       <= cnt_q + 1'b1;
          // Leave RUN on the last code so the wrap to 0 never issues again.
          if (cnt_q == CODE_MAX) state_q <= CHECK;
        end
        CHECK: begin
          // Final compare lands this edge; errs_d already includes it.
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (errs_d == '0);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.D         = d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bist_busy = busy_q;
  assign bus.bist_done = done_q;
  assign bus.bist_pass = pass_q;
  assign bus.bist_errs = errs_q;

endmodule
